dmem_arbiter: RTL and testbench

- Arbitrates one single-port synchronous data RAM (8-bit address, 8-bit data) between two requesters: the CPU load/store path and a host loader/debug port.
- The host port preloads data and inspects it while the CPU runs.
- Sits between the CPU datapath (LOAD write-back source, STORE write enable) and the data memory.
- Provides a per-cycle grant, a one-cycle read return routed to the owning requester, and bounded host bursts.

---
 rtl/dmem_arbiter.sv | 85 ++++++++
 tb/tb_dmem_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/host arbiter for a single-port data RAM with host bursts; DMEM_ARB_CONFLICT_CNT_EN adds a conflict counter
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic          host_lock,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef DMEM_ARB_CONFLICT_CNT_EN
  , output logic [7:0]  conflict_cnt
`endif
);
  typedef enum logic {ARB_RR, ARB_HOST_BURST} arb_t;
  arb_t state, state_n;
  logic last_host, rd_pend, rd_host, cap;
  logic [3:0] hold_cnt;
  logic [DW-1:0] cpu_rq, host_rq;
  // grant selection: burst favours host until the CPU has waited MAX_HOLD host grants
  always_comb begin
    cap = cpu_req && hold_cnt == 4'(MAX_HOLD);
    host_gnt = !reset && host_req && (state == ARB_HOST_BURST ? !cap : !(cpu_req && last_host));
    cpu_gnt = !reset && cpu_req && !host_gnt;
    state_n = host_lock && host_req && (host_gnt || state == ARB_HOST_BURST) ? ARB_HOST_BURST : ARB_RR;
  end
  // memory port mux and read-return routing
  always_comb begin
    mem_en = cpu_gnt | host_gnt;
    mem_we = host_gnt ? host_we : cpu_gnt & cpu_we;
    mem_addr = host_gnt ? host_addr : cpu_gnt ? cpu_addr : '0;
    mem_wdata = host_gnt ? host_wdata : cpu_gnt ? cpu_wdata : '0;
    cpu_rvalid = rd_pend && !rd_host;
    host_rvalid = rd_pend && rd_host;
    cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rq;
    host_rdata = host_rvalid ? mem_rdata : host_rq;
    busy = rd_pend;
  end
  // arbiter state, fairness history, hold counter, owner tag and held read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARB_RR;
      last_host <= 1'b1;
      hold_cnt <= '0;
      rd_pend <= 1'b0;
      rd_host <= 1'b0;
      cpu_rq <= '0;
      host_rq <= '0;
    end else begin
      state <= state_n;
      last_host <= mem_en ? host_gnt : last_host;
      hold_cnt <= (cpu_gnt || !cpu_req) ? '0 : hold_cnt + 4'(host_gnt);
      rd_pend <= mem_en && !mem_we;
      rd_host <= host_gnt;
      cpu_rq <= cpu_rdata;
      host_rq <= host_rdata;
    end
  end
`ifdef DMEM_ARB_CONFLICT_CNT_EN
  // saturating count of cycles where both sides request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) conflict_cnt <= '0;
    else conflict_cnt <= conflict_cnt + 8'(cpu_req && host_req && conflict_cnt != 8'hFF);
  end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  logic clk = 0, reset = 1;
  logic cpu_req = 0, cpu_we = 0, host_req = 0, host_we = 0, host_lock = 0;
  logic [7:0] cpu_addr = 0, cpu_wdata = 0, host_addr = 0, host_wdata = 0;
  logic cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, mem_en, mem_we, busy;
  logic [7:0] cpu_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [7:0] ram [256];
  int total = 0, bad = 0;
`ifdef DMEM_ARB_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt;
`endif
  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_lock(host_lock), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
`ifdef DMEM_ARB_CONFLICT_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[0] = 8'hA1;
    ram[1] = 8'hB2;
    mem_rdata = 8'h00;
    cpu_req = 1; host_req = 1; host_wdata = 8'h5A; cpu_wdata = 8'h77;
    cyc; cyc;
    @(negedge clk);
    chk("rst_cgnt", cpu_gnt, 0);
    chk("rst_hgnt", host_gnt, 0);
    chk("rst_en", mem_en, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", {cpu_rvalid, host_rvalid}, 0);
    chk("rst_rdata", {cpu_rdata, host_rdata}, 0);
    cyc;
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_c", cpu_gnt, 32'(i % 2 == 0));
      chk("rr_h", host_gnt, 32'(i % 2 == 1));
      cyc;
    end
    cpu_req = 0;
    host_req = 1; host_we = 1; host_addr = 8'h10; host_wdata = 8'h3C;
    @(negedge clk);
    chk("hw_gnt", host_gnt, 1);
    chk("hw_we", mem_we, 1);
    chk("hw_addr", mem_addr, 8'h10);
    chk("hw_wdata", mem_wdata, 8'h3C);
    chk("hw_prev_rd", host_rdata, 8'hA1);
    cyc;
    host_req = 0; host_we = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    @(negedge clk);
    chk("cr_gnt", cpu_gnt, 1);
    chk("cr_we", mem_we, 0);
    chk("hw_no_rv", host_rvalid, 0);
    chk("hw_no_busy", busy, 0);
    cyc;
    cpu_req = 0;
    @(negedge clk);
    chk("cr_rv", cpu_rvalid, 1);
    chk("cr_rdata", cpu_rdata, 8'h3C);
    chk("cr_hrv", host_rvalid, 0);
    chk("cr_hold", host_rdata, 8'hA1);
    chk("cr_busy", busy, 1);
    chk("idle_addr", mem_addr, 0);
    cyc;
    cpu_req = 1; cpu_addr = 8'h00;
    @(negedge clk);
    chk("b2b_g0", cpu_gnt, 1);
    cyc;
    cpu_addr = 8'h01;
    @(negedge clk);
    chk("b2b_g1", cpu_gnt, 1);
    chk("b2b_rv0", cpu_rvalid, 1);
    chk("b2b_rd0", cpu_rdata, 8'hA1);
    chk("b2b_busy0", busy, 1);
    cyc;
    cpu_req = 0;
    @(negedge clk);
    chk("b2b_rv1", cpu_rvalid, 1);
    chk("b2b_rd1", cpu_rdata, 8'hB2);
    chk("b2b_busy1", busy, 1);
    cyc;
    @(negedge clk);
    chk("b2b_rv2", cpu_rvalid, 0);
    chk("b2b_busy2", busy, 0);
    chk("b2b_hold", cpu_rdata, 8'hB2);
    cyc;
    host_lock = 1; host_req = 1; host_we = 1; host_addr = 8'h20; host_wdata = 8'h55;
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h21; cpu_wdata = 8'h66;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("burst_h", host_gnt, 32'(i % 5 != 4));
      chk("burst_c", cpu_gnt, 32'(i % 5 == 4));
      cyc;
    end
    host_lock = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("exit_h", host_gnt, 32'(i != 1));
      chk("exit_c", cpu_gnt, 32'(i == 1));
      cyc;
    end
    cpu_req = 0; cpu_we = 0;
    host_we = 0; host_addr = 8'h10;
    @(negedge clk);
    chk("mr_gnt", host_gnt, 1);
    cyc;
    host_req = 0;
    reset = 1;
    @(negedge clk);
    chk("mr_rv", host_rvalid, 0);
    chk("mr_rdata", host_rdata, 0);
    chk("mr_busy", busy, 0);
    cyc;
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mr_post_rv", {cpu_rvalid, host_rvalid}, 0);
      cyc;
    end
`ifdef DMEM_ARB_CONFLICT_CNT_EN
    cpu_req = 1; host_req = 1;
    repeat (300) cyc;
    @(negedge clk);
    chk("cc_sat", conflict_cnt, 8'hFF);
    repeat (5) cyc;
    @(negedge clk);
    chk("cc_stay", conflict_cnt, 8'hFF);
    cpu_req = 0; host_req = 0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
